mostra_sequencia_controle: RTL and testbench



---
 rtl/mostra_sequencia_controle_pkg.sv | 16 +
 rtl/mostra_sequencia_controle_temporizador_led.sv | 37 +++
 rtl/mostra_sequencia_controle.sv | 129 ++++++++++++
 tb/tb_mostra_sequencia_controle.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mostra_sequencia_controle_pkg.sv
// Shared definitions for the LED sequence-playback controller: state codes
// shown on db_estado and default lit/blank durations.
package mostra_sequencia_controle_pkg;

  typedef enum logic [3:0] {
    OCIOSO  = 4'h0,
    CARREGA = 4'h1,
    ACESO   = 4'h2,
    APAGADO = 4'h3,
    FIM     = 4'hF
  } estado_t;

  localparam int T_ACESO_PADRAO   = 1000;
  localparam int T_APAGADO_PADRAO = 500;

endpackage

// File: rtl/mostra_sequencia_controle_temporizador_led.sv
// Phase timer: counts while conta=1, clears on zera, flags the last cycle
// of a LIMITE-cycle window.
module temporizador_led #(
  parameter int LIMITE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim_tempo
);

  localparam int LARGURA = (LIMITE > 1) ? $clog2(LIMITE) : 1;
  localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(LIMITE - 1);

  logic [LARGURA-1:0] contagem_q, contagem_d;

  always_comb begin
    contagem_d = contagem_q;
    if (zera) begin
      contagem_d = '0;
    end else if (conta) begin
      contagem_d = contagem_q + LARGURA'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign fim_tempo = (contagem_q == ULTIMO);

endmodule

// File: rtl/mostra_sequencia_controle.sv
// Plays the stored colour sequence on the LEDs, entry 0 up to the sampled
// round, each lit for T_ACESO cycles followed by a T_APAGADO blank gap.
module mostra_sequencia_controle
  import mostra_sequencia_controle_pkg::*;
#(
  parameter int T_ACESO   = T_ACESO_PADRAO,
  parameter int T_APAGADO = T_APAGADO_PADRAO,
  parameter int W         = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         parar,
  input  logic [W-1:0] rodada,
  input  logic [W-1:0] dado_memoria,
  output logic [W-1:0] endereco,
  output logic [W-1:0] leds,
  output logic         ocupado,
  output logic         fim,
  output logic [3:0]   db_estado
);

  estado_t        estado_q, estado_d;
  logic [W-1:0]   endereco_q, endereco_d;
  logic [W-1:0]   leds_q, leds_d;
  logic [W-1:0]   rodada_q, rodada_d;
  logic           ocupado_q, ocupado_d;
  logic           fim_q, fim_d;
  logic           fim_aceso, fim_apagado;

  // Each timer is held at zero outside its own phase, so it always starts
  // from 0 on phase entry.
  temporizador_led #(.LIMITE(T_ACESO)) u_tempo_aceso (
    .clock     (clock),
    .reset     (reset),
    .zera      (estado_q != ACESO),
    .conta     (estado_q == ACESO),
    .fim_tempo (fim_aceso)
  );

  temporizador_led #(.LIMITE(T_APAGADO)) u_tempo_apagado (
    .clock     (clock),
    .reset     (reset),
    .zera      (estado_q != APAGADO),
    .conta     (estado_q == APAGADO),
    .fim_tempo (fim_apagado)
  );

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    leds_d     = leds_q;
    rodada_d   = rodada_q;
    case (estado_q)
      OCIOSO: begin
        leds_d = '0;
        if (iniciar && !parar) begin
          rodada_d   = rodada;
          endereco_d = '0;
          estado_d   = CARREGA;
        end
      end
      CARREGA: begin
        leds_d   = dado_memoria;
        estado_d = ACESO;
      end
      ACESO: begin
        if (fim_aceso) begin
          leds_d   = '0;
          estado_d = APAGADO;
        end
      end
      APAGADO: begin
        leds_d = '0;
        if (fim_apagado) begin
          if (endereco_q == rodada_q) begin
            estado_d = FIM;
          end else begin
            endereco_d = endereco_q + W'(1);
            estado_d   = CARREGA;
          end
        end
      end
      FIM: begin
        leds_d   = '0;
        estado_d = OCIOSO;
      end
      default: begin
        leds_d   = '0;
        estado_d = OCIOSO;
      end
    endcase

    // Abort drops straight back to idle without a completion pulse.
    if (parar && (estado_q != OCIOSO)) begin
      estado_d   = OCIOSO;
      leds_d     = '0;
      endereco_d = '0;
    end

    ocupado_d = (estado_d == CARREGA) || (estado_d == ACESO) || (estado_d == APAGADO);
    fim_d     = (estado_d == FIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      leds_q     <= '0;
      rodada_q   <= '0;
      ocupado_q  <= 1'b0;
      fim_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      leds_q     <= leds_d;
      rodada_q   <= rodada_d;
      ocupado_q  <= ocupado_d;
      fim_q      <= fim_d;
    end
  end

  assign endereco  = endereco_q;
  assign leds      = leds_q;
  assign ocupado   = ocupado_q;
  assign fim       = fim_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_mostra_sequencia_controle.sv
// Directed bench for the playback controller with T_ACESO=4, T_APAGADO=2
// (7 cycles per entry); outputs are sampled 1 time unit after each edge.
module tb_mostra_sequencia_controle;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       parar = 1'b0;
  logic [3:0] rodada = 4'd0;
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       fim;
  logic [3:0] db_estado;

  logic [3:0] mem [16];
  int n_checks = 0;
  int n_fails  = 0;

  always #5 clock = ~clock;

  assign dado_memoria = mem[endereco];

  mostra_sequencia_controle #(
    .T_ACESO   (4),
    .T_APAGADO (2),
    .W         (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .parar        (parar),
    .rodada       (rodada),
    .dado_memoria (dado_memoria),
    .endereco     (endereco),
    .leds         (leds),
    .ocupado      (ocupado),
    .fim          (fim),
    .db_estado    (db_estado)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [13:0] observado();
    return {db_estado, leds, endereco, ocupado, fim};
  endfunction

  // Expected {db_estado, leds, endereco, ocupado, fim} in cycle c after iniciar
  // was sampled (cycle 1 = CARREGA of entry 0) for a run of round r.
  function automatic logic [13:0] esperado(input int r, input int c);
    int n;
    int e;
    int p;
    n = (r + 1) * 7 + 1;
    if (c == n) return {4'hF, 4'h0, 4'(r), 1'b0, 1'b1};
    if (c > n)  return {4'h0, 4'h0, 4'(r), 1'b0, 1'b0};
    e = (c - 1) / 7;
    p = (c - 1) % 7;
    if (p == 0) return {4'h1, 4'h0, 4'(e), 1'b1, 1'b0};
    if (p <= 4) return {4'h2, mem[e], 4'(e), 1'b1, 1'b0};
    return {4'h3, 4'h0, 4'(e), 1'b1, 1'b0};
  endfunction

  task automatic test_reset();
    logic [13:0] obs;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    obs = observado();
    n_checks++;
    if (obs !== 14'h0) begin
      n_fails++;
      $display("FAIL reset_state obs=%h exp=%h", obs, 14'h0);
    end
    $display("test_reset: outputs after reset %h", obs);
    for (int i = 0; i < 20; i++) begin
      tick();
      obs = observado();
      n_checks++;
      if (obs !== 14'h0) begin
        n_fails++;
        $display("FAIL idle_hold cycle=%0d obs=%h exp=%h", i, obs, 14'h0);
      end
    end
    $display("test_reset: 20 idle cycles checked");
  endtask

  task automatic test_rodada_2();
    logic [13:0] obs;
    logic [13:0] esp;
    int fims;
    int ocup;
    int fim_ciclo;
    fims = 0;
    ocup = 0;
    fim_ciclo = -1;
    for (int a = 0; a < 16; a++) mem[a] = 4'h0;
    mem[0] = 4'h1;
    mem[1] = 4'h2;
    mem[2] = 4'h4;
    rodada = 4'd2;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      obs = observado();
      esp = esperado(2, c);
      n_checks++;
      if (obs !== esp) begin
        n_fails++;
        $display("FAIL rodada2 cycle=%0d obs=%h exp=%h", c, obs, esp);
      end
      if (fim === 1'b1) begin
        fims++;
        fim_ciclo = c;
      end
      if (ocupado === 1'b1) ocup++;
      tick();
    end
    n_checks++;
    if (fims != 1 || fim_ciclo != 22) begin
      n_fails++;
      $display("FAIL rodada2_fim pulses=%0d at=%0d exp pulses=1 at=22", fims, fim_ciclo);
    end
    n_checks++;
    if (ocup != 21) begin
      n_fails++;
      $display("FAIL rodada2_ocupado cycles=%0d exp=21", ocup);
    end
    $display("test_rodada_2: fim at cycle %0d, ocupado for %0d cycles", fim_ciclo, ocup);
  endtask

  task automatic test_limites();
    logic [13:0] obs;
    logic [13:0] esp;
    int r;
    int n;
    int max_end;
    int fim_ciclo;
    for (int a = 0; a < 16; a++) mem[a] = 4'(a + 1);
    for (int k = 0; k < 2; k++) begin
      r = (k == 0) ? 0 : 15;
      n = (r + 1) * 7 + 1;
      max_end = 0;
      fim_ciclo = -1;
      rodada = 4'(r);
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      for (int c = 1; c <= n + 2; c++) begin
        obs = observado();
        esp = esperado(r, c);
        n_checks++;
        if (obs !== esp) begin
          n_fails++;
          $display("FAIL limite_r%0d cycle=%0d obs=%h exp=%h", r, c, obs, esp);
        end
        if (int'(endereco) > max_end) max_end = int'(endereco);
        if (fim === 1'b1 && fim_ciclo < 0) fim_ciclo = c;
        tick();
      end
      n_checks++;
      if (fim_ciclo != n || max_end != r) begin
        n_fails++;
        $display("FAIL limite_r%0d_resumo fim_at=%0d max_end=%0d exp fim_at=%0d max_end=%0d",
                 r, fim_ciclo, max_end, n, r);
      end
      $display("test_limites: rodada=%0d fim at cycle %0d, peak endereco %0d", r, fim_ciclo, max_end);
    end
  endtask

  task automatic test_ignora_iniciar();
    logic [13:0] obs;
    logic [13:0] esp;
    for (int a = 0; a < 16; a++) mem[a] = 4'(15 - a);
    rodada = 4'd3;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      obs = observado();
      esp = esperado(3, c);
      n_checks++;
      if (obs !== esp) begin
        n_fails++;
        $display("FAIL ignora_iniciar cycle=%0d obs=%h exp=%h", c, obs, esp);
      end
      iniciar = (c == 3 || c == 29) ? 1'b1 : 1'b0;
      if (c == 3) rodada = 4'd5;
      tick();
    end
    iniciar = 1'b0;
    rodada = 4'd0;
    $display("test_ignora_iniciar: run of rodada=3 with iniciar/rodada changes mid-run and in FIM");
  endtask

  task automatic test_parar();
    logic [13:0] obs;
    logic [13:0] esp;
    for (int a = 0; a < 16; a++) mem[a] = 4'(a + 1);
    rodada = 4'd2;
    parar = 1'b1;
    iniciar = 1'b1;
    tick();
    parar = 1'b0;
    iniciar = 1'b0;
    obs = observado();
    n_checks++;
    if (obs[13:10] !== 4'h0 || obs[1] !== 1'b0) begin
      n_fails++;
      $display("FAIL parar_vence_iniciar db=%h ocupado=%b exp db=0 ocupado=0", obs[13:10], obs[1]);
    end
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      obs = observado();
      esp = esperado(2, c);
      n_checks++;
      if (obs !== esp) begin
        n_fails++;
        $display("FAIL parar_pre cycle=%0d obs=%h exp=%h", c, obs, esp);
      end
      if (c == 13) parar = 1'b1;
      tick();
    end
    parar = 1'b0;
    obs = observado();
    n_checks++;
    if (obs !== 14'h0) begin
      n_fails++;
      $display("FAIL parar_ocioso obs=%h exp=%h", obs, 14'h0);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      obs = observado();
      n_checks++;
      if (obs !== 14'h0) begin
        n_fails++;
        $display("FAIL parar_sem_fim cycle=%0d obs=%h exp=%h", i, obs, 14'h0);
      end
    end
    rodada = 4'd1;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      obs = observado();
      esp = esperado(1, c);
      n_checks++;
      if (obs !== esp) begin
        n_fails++;
        $display("FAIL parar_reinicio cycle=%0d obs=%h exp=%h", c, obs, esp);
      end
      tick();
    end
    $display("test_parar: abort in APAGADO of entry 1, then clean rerun of rodada=1");
  endtask

  task automatic test_reset_meio();
    logic [13:0] obs;
    logic [13:0] esp;
    for (int a = 0; a < 16; a++) mem[a] = 4'h9;
    rodada = 4'd2;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      obs = observado();
      esp = esperado(2, c);
      n_checks++;
      if (obs !== esp) begin
        n_fails++;
        $display("FAIL reset_meio_pre cycle=%0d obs=%h exp=%h", c, obs, esp);
      end
      if (c == 3) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    obs = observado();
    n_checks++;
    if (obs !== 14'h0) begin
      n_fails++;
      $display("FAIL reset_meio obs=%h exp=%h", obs, 14'h0);
    end
    tick();
    obs = observado();
    n_checks++;
    if (obs !== 14'h0) begin
      n_fails++;
      $display("FAIL reset_meio_idle obs=%h exp=%h", obs, 14'h0);
    end
    $display("test_reset_meio: reset during ACESO returns to idle");
  endtask

  initial begin
    for (int a = 0; a < 16; a++) mem[a] = 4'h0;
    test_reset();
    test_rodada_2();
    test_limites();
    test_ignora_iniciar();
    test_parar();
    test_reset_meio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
